// File: rtl/sawtooth_period_meter.sv
// Measures sawtooth period, peak and trough from a digitized capacitor voltage.
// A discharge edge is a sample-to-sample fall of at least DROP_TH codes.
module sawtooth_period_meter #(
  parameter int DATA_W  = 10,
  parameter int CNT_W   = 16,
  parameter int DROP_TH = 64,
  parameter int HOLDOFF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  m_period,
  output logic [DATA_W-1:0] m_peak,
  output logic [DATA_W-1:0] m_trough,
  output logic              m_sat,
  output logic              overrun,
  output logic              locked
);

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
  localparam logic [DATA_W:0]   DROP_V    = (DATA_W + 1)'(DROP_TH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // SEEK: wait for first edge | HOLD: edges blocked | RAMP: measuring a cycle
  typedef enum logic [1:0] {SEEK, HOLD, RAMP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [DATA_W-1:0]   trough_q, trough_d;
  logic                m_valid_q, m_valid_d;
  logic [CNT_W-1:0]    m_period_q, m_period_d;
  logic [DATA_W-1:0]   m_peak_q, m_peak_d;
  logic [DATA_W-1:0]   m_trough_q, m_trough_d;
  logic                m_sat_q, m_sat_d;
  logic                overrun_q, overrun_d;
  logic                locked_q, locked_d;

  logic [DATA_W:0] drop;
  logic            is_edge;
  logic            open_cyc;
  logic            track;
  logic            emit;

  assign drop    = {1'b0, prev_q} - {1'b0, s_data};
  assign is_edge = prev_vld_q && (prev_q > s_data) && (drop >= DROP_V);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    peak_d     = peak_q;
    trough_d   = trough_q;
    m_valid_d  = m_valid_q;
    m_period_d = m_period_q;
    m_peak_d   = m_peak_q;
    m_trough_d = m_trough_q;
    m_sat_d    = m_sat_q;
    overrun_d  = overrun_q;
    locked_d   = locked_q;
    open_cyc   = 1'b0;
    track      = 1'b0;
    emit       = 1'b0;

    if (s_valid) begin
      prev_d     = s_data;
      prev_vld_d = 1'b1;
      case (state_q)
        SEEK: if (is_edge) begin
          open_cyc = 1'b1;
          locked_d = 1'b1;
        end
        HOLD: begin
          track  = 1'b1;
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) state_d = RAMP;
        end
        RAMP: if (is_edge) begin
          open_cyc = 1'b1;
          emit     = 1'b1;
        end else begin
          track = 1'b1;
        end
        default: state_d = SEEK;
      endcase
    end

    if (open_cyc) begin
      cnt_d    = CNT_W'(1);
      sat_d    = 1'b0;
      peak_d   = s_data;
      trough_d = s_data;
      hold_d   = HOLD_LOAD;
      state_d  = (HOLDOFF == 0) ? RAMP : HOLD;
    end

    if (track) begin
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
      if (s_data > peak_q)   peak_d   = s_data;
      if (s_data < trough_q) trough_d = s_data;
    end

    // A fresh result always wins over a pending one; the loss is flagged only if unaccepted.
    if (emit) begin
      m_valid_d  = 1'b1;
      m_period_d = cnt_q;
      m_peak_d   = peak_q;
      m_trough_d = trough_q;
      m_sat_d    = sat_q;
      if (m_valid_q && !m_ready) overrun_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      hold_q     <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      peak_q     <= '0;
      trough_q   <= '0;
      m_valid_q  <= 1'b0;
      m_period_q <= '0;
      m_peak_q   <= '0;
      m_trough_q <= '0;
      m_sat_q    <= 1'b0;
      overrun_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      peak_q     <= peak_d;
      trough_q   <= trough_d;
      m_valid_q  <= m_valid_d;
      m_period_q <= m_period_d;
      m_peak_q   <= m_peak_d;
      m_trough_q <= m_trough_d;
      m_sat_q    <= m_sat_d;
      overrun_q  <= overrun_d;
      locked_q   <= locked_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_period = m_period_q;
  assign m_peak   = m_peak_q;
  assign m_trough = m_trough_q;
  assign m_sat    = m_sat_q;
  assign overrun  = overrun_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_sawtooth_period_meter.sv
// Directed bench for sawtooth_period_meter: default instance plus a CNT_W=4 instance for saturation.
module tb_sawtooth_period_meter;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [9:0] s_data;
  logic       m_ready;

  logic        m_valid, m_sat, overrun, locked;
  logic [15:0] m_period;
  logic [9:0]  m_peak, m_trough;

  logic       s4_valid, s4_sat, s4_overrun, s4_locked;
  logic [3:0] s4_period;
  logic [9:0] s4_peak, s4_trough;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_n   = 0;

  sawtooth_period_meter dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_period (m_period),
    .m_peak   (m_peak),
    .m_trough (m_trough),
    .m_sat    (m_sat),
    .overrun  (overrun),
    .locked   (locked)
  );

  sawtooth_period_meter #(.DATA_W(10), .CNT_W(4), .DROP_TH(64), .HOLDOFF(4)) dut_s4 (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .m_valid  (s4_valid),
    .m_ready  (m_ready),
    .m_period (s4_period),
    .m_peak   (s4_peak),
    .m_trough (s4_trough),
    .m_sat    (s4_sat),
    .overrun  (s4_overrun),
    .locked   (s4_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && m_valid && m_ready) acc_n <= acc_n + 1;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d);
    s_valid = 1'b1;
    s_data  = 10'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int n, input int step, input int first);
    for (int i = first; i < n; i++) push(i * step);
  endtask

  task automatic ramp_gap(input int n, input int first);
    for (int i = first; i < n; i++) begin
      push(i);
      idle(1);
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_period", m_period, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;

    // basic ramp 0..99 with consumer always ready
    ramp(100, 1, 0);
    chk("seek_no_lock", locked, 0);
    push(0);
    chk("first_edge_lock", locked, 1);
    chk("first_edge_no_result", m_valid, 0);
    ramp(100, 1, 1);
    push(0);
    chk("ramp_valid", m_valid, 1);
    chk("ramp_period", m_period, 100);
    chk("ramp_peak", m_peak, 99);
    chk("ramp_trough", m_trough, 0);
    chk("ramp_sat", m_sat, 0);
    ramp(100, 1, 1);
    chk("ramp_accepted", m_valid, 0);
    chk("ramp_acc_n1", acc_n, 1);
    push(0);
    ramp(100, 1, 1);
    chk("ramp_acc_n2", acc_n, 2);

    // consumer stalls for 250 samples
    m_ready = 1'b0;
    push(0);
    ramp(100, 1, 1);
    chk("stall_valid", m_valid, 1);
    chk("stall_no_overrun_yet", overrun, 0);
    push(0);
    chk("stall_overrun", overrun, 1);
    ramp(100, 1, 1);
    ramp(50, 1, 0);
    chk("stall_valid_held", m_valid, 1);
    chk("stall_period_held", m_period, 100);
    m_ready = 1'b1;
    chk("stall_valid_before_hs", m_valid, 1);
    idle(1);
    chk("stall_valid_dropped", m_valid, 0);
    chk("stall_overrun_sticky", overrun, 1);

    // s_valid toggling every other clock
    ramp_gap(100, 50);
    push(0);
    chk("gap_valid", m_valid, 1);
    chk("gap_period_a", m_period, 100);
    chk("gap_peak", m_peak, 99);
    ramp_gap(100, 1);
    push(0);
    chk("gap_period_b", m_period, 100);

    // dips: 70 within holdoff ignored, 50 mid-ramp ignored
    push(100);
    push(30);
    chk("dip70_holdoff_ignored", m_valid, 0);
    push(101);
    push(102);
    for (int i = 103; i < 150; i++) push(i);
    push(99);
    chk("dip50_ignored", m_valid, 0);
    for (int i = 150; i < 200; i++) push(i);
    push(0);
    chk("dip_period", m_period, 103);
    chk("dip_peak", m_peak, 199);
    chk("dip_trough", m_trough, 0);

    // 70-code dip after holdoff is an early edge
    push(1); push(2); push(3); push(4); push(80);
    push(10);
    chk("early_valid", m_valid, 1);
    chk("early_period", m_period, 6);
    chk("early_peak", m_peak, 80);
    chk("early_trough", m_trough, 0);

    // first sample after holdoff may already be an edge
    push(11); push(12); push(13); push(90);
    push(20);
    chk("holdoff_bound_valid", m_valid, 1);
    chk("holdoff_bound_period", m_period, 5);
    chk("holdoff_bound_peak", m_peak, 90);
    chk("holdoff_bound_trough", m_trough, 10);

    // drop threshold boundary: 63 no edge, 64 edge
    push(21); push(22); push(23); push(100);
    push(37);
    chk("drop63_no_edge", m_valid, 0);
    push(101);
    m_ready = 1'b0;
    push(37);
    chk("drop64_period", m_period, 7);
    chk("drop64_peak", m_peak, 101);
    chk("drop64_trough", m_trough, 20);

    // asynchronous reset 40 samples into a cycle
    ramp(78, 1, 38);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_period", m_period, 0);
    chk("arst_m_peak", m_peak, 0);
    chk("arst_m_trough", m_trough, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_locked", locked, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    push(150);
    chk("post_rst_first_no_lock", locked, 0);
    push(50);
    chk("post_rst_edge1_lock", locked, 1);
    chk("post_rst_edge1_no_result", m_valid, 0);
    ramp(150, 1, 51);
    push(50);
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_period", m_period, 100);
    chk("post_rst_peak", m_peak, 149);
    chk("post_rst_trough", m_trough, 50);

    // handshake and new emit in the same cycle
    ramp(150, 1, 51);
    m_ready = 1'b0;
    push(50);
    chk("sim_first_valid", m_valid, 1);
    push(51); push(52); push(53); push(54); push(120);
    m_ready = 1'b1;
    push(40);
    chk("sim_valid", m_valid, 1);
    chk("sim_period", m_period, 6);
    chk("sim_peak", m_peak, 120);
    chk("sim_trough", m_trough, 50);
    chk("sim_no_overrun", overrun, 0);
    idle(1);
    chk("sim_valid_dropped", m_valid, 0);

    // saturation on the CNT_W=4 instance
    do_reset();
    ramp(20, 5, 0);
    push(0);
    ramp(20, 5, 1);
    push(0);
    chk("sat4_valid", s4_valid, 1);
    chk("sat4_period", s4_period, 15);
    chk("sat4_sat", s4_sat, 1);
    chk("sat4_peak", s4_peak, 95);
    chk("sat4_trough", s4_trough, 0);
    chk("sat16_period", m_period, 20);
    chk("sat16_sat", m_sat, 0);
    ramp(14, 5, 1);
    push(0);
    chk("sat4_clear_period", s4_period, 14);
    chk("sat4_clear_sat", s4_sat, 0);
    chk("sat16_short_period", m_period, 14);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sawtooth_period_meter.md
SAWTOOTH_PERIOD_METER -- requirements
Module: sawtooth_period_meter

Interface
REQ-001 SHALL have parameter DATA_W, default 10, width of the digitized sawtooth sample.
REQ-002 SHALL have parameter CNT_W, default 16, width of the period counter and result.
REQ-003 SHALL have parameter DROP_TH, default 64, minimum sample-to-sample fall, in codes, that marks a discharge edge.
REQ-004 SHALL have parameter HOLDOFF, default 4, number of accepted samples after a discharge edge during which edge detection is blocked.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port s_valid, input, 1, sample strobe; a sample is accepted on every clk edge with s_valid=1 (no backpressure).
REQ-008 SHALL have port s_data, input, DATA_W, unsigned ADC code of the capacitor (Out) voltage.
REQ-009 SHALL have port m_valid, output, 1, result available.
REQ-010 SHALL have port m_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port m_period, output, CNT_W, samples per sawtooth cycle.
REQ-012 SHALL have port m_peak, output, DATA_W, maximum sample in the cycle.
REQ-013 SHALL have port m_trough, output, DATA_W, minimum sample in the cycle.
REQ-014 SHALL have port m_sat, output, 1, period counter saturated during the cycle.
REQ-015 SHALL have port overrun, output, 1, sticky: a result was dropped because the previous one was not yet accepted.
REQ-016 SHALL have port locked, output, 1, high once at least one discharge edge has been seen.

Function
REQ-017 SHALL register the previous accepted sample (prev); edge condition = prev > s_data and (prev - s_data) >= DROP_TH, computed at DATA_W+1 bits, no wrap.
REQ-018 SHALL implement FSM states SEEK, HOLD, RAMP.
REQ-019 SEEK: waits for first edge; no counting; first accepted sample never triggers (no prev); on edge -> HOLD, locked:=1, no result emitted.
REQ-020 HOLD: edges ignored; after HOLDOFF accepted samples -> RAMP; HOLDOFF=0 SHALL go straight to RAMP.
REQ-021 RAMP: on edge, emit result for the closing cycle, -> HOLD; otherwise stay.
REQ-022 On any edge, cnt:=1, peak:=s_data, trough:=s_data (edge sample opens new cycle); on other accepted samples in HOLD/RAMP, cnt:=cnt+1 saturating at 2^CNT_W-1 with sat:=1, peak:=max, trough:=min.
REQ-023 Emitted result: m_period=cnt, m_peak=peak, m_trough=trough, m_sat=sat, all taken before the edge-sample update; m_valid rises the cycle after the edge sample (latency 1 clk).
REQ-024 m_valid SHALL stay high and outputs stable until m_valid & m_ready; then m_valid:=0 next cycle.
REQ-025 If a new result is emitted while m_valid=1 and m_ready=0 that cycle, SHALL overwrite outputs with the new result, keep m_valid=1, set overrun:=1.
REQ-026 Simultaneous handshake completion and new emit in same cycle SHALL load the new result, m_valid stays 1, no overrun.
REQ-027 Cycles with s_valid=0 SHALL change no counter/tracking state.

Reset
REQ-028 rst=1 SHALL immediately force: state SEEK, cnt=0, sat=0, prev invalid, m_valid=0, m_period=0, m_peak=0, m_trough=0, m_sat=0, overrun=0, locked=0.
REQ-029 Reset mid-cycle SHALL discard the partial cycle; first result after reset requires two new edges.
REQ-030 overrun SHALL clear only by reset.

Verification
REQ-031 Ramp 0..99 step 1, repeated, s_valid=1, m_ready=1 -> after second edge: m_period=100, m_peak=99, m_trough=0, m_sat=0, one result per 100 samples.
REQ-032 Same ramp, m_ready=0 for 250 samples -> overrun=1, m_period=100 held until m_ready asserted, then m_valid drops one cycle later.
REQ-033 Ramp with a 50-code dip mid-cycle (DROP_TH=64) -> no edge, period unchanged; 70-code dip within HOLDOFF -> ignored; 70-code dip after HOLDOFF -> early edge, short period reported.
REQ-034 CNT_W=4, ramp of 20 samples -> m_period=15, m_sat=1.
REQ-035 s_valid toggling every other clk on the 100-sample ramp -> m_period=100 unchanged.
REQ-036 rst asserted at sample 40 of a cycle -> all outputs 0 asynchronously; next result only after two edges.
